imem_preloader: RTL

//  Synthesizable boot loader for the instruction RAM of the pipelined CPU. Accepts a stream of

---
 rtl/imem_preloader_if.sv | 29 ++
 rtl/imem_preloader.sv | 112 +++++++++++
 2 files changed

// File: rtl/imem_preloader_if.sv
// Streaming-input and instruction-RAM write bus of the boot loader.
// The slave side is the loader; the master side is the image source / observer.
interface imem_preloader_if #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 32
);
  logic              start;
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_count;

  modport master (
    output start, in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err, word_count
  );

  modport slave (
    input  start, in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err, word_count
  );
endinterface

// File: rtl/imem_preloader.sv
// Boot loader: takes instruction words over valid/ready and writes them byte-serially
// into the byte-addressed instruction RAM, holding the CPU in reset until the image is in.
module imem_preloader #(
  parameter int ADDR_W     = 8,
  parameter int WORD_W     = 32,
  parameter int BIG_ENDIAN = 1,
  parameter int START_ADDR = 0
) (
  input logic             clk,
  input logic             reset,
  imem_preloader_if.slave bus
);

  localparam int BPW   = WORD_W / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BPW - 1);
  localparam logic [ADDR_W-1:0] TOP_ADDR  = '1;
  localparam logic [ADDR_W-1:0] START_PTR = ADDR_W'(START_ADDR);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCEPT = 3'd1;
  localparam logic [2:0] ST_WRITE  = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_ERR    = 3'd4;

  logic [2:0]        r_state;
  logic [WORD_W-1:0] r_word;
  logic              r_last;
  logic [ADDR_W-1:0] r_ptr;
  logic [CNT_W-1:0]  r_byte_idx;
  logic [ADDR_W:0]   r_word_count;

  logic              w_writing;
  logic              w_last_byte;
  logic              w_at_top;
  logic [7:0]        w_byte;
  logic [WORD_W-1:0] w_word_next;

  // The captured word is shifted one byte per write so the outgoing byte always sits at a fixed end.
  generate
    if (BIG_ENDIAN != 0) begin : g_big
      assign w_byte      = r_word[WORD_W-1 -: 8];
      assign w_word_next = r_word << 8;
    end else begin : g_little
      assign w_byte      = r_word[7:0];
      assign w_word_next = r_word >> 8;
    end
  endgenerate

  assign w_writing   = (r_state == ST_WRITE);
  assign w_last_byte = (r_byte_idx == LAST_BYTE);
  assign w_at_top    = (r_ptr == TOP_ADDR);

  assign bus.in_ready   = (r_state == ST_ACCEPT);
  assign bus.mem_we     = w_writing;
  assign bus.mem_addr   = r_ptr;
  assign bus.mem_wdata  = w_writing ? w_byte : 8'h00;
  assign bus.cpu_hold   = (r_state != ST_DONE);
  assign bus.done       = (r_state == ST_DONE);
  assign bus.err        = (r_state == ST_ERR);
  assign bus.word_count = r_word_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_word       <= '0;
      r_last       <= 1'b0;
      r_ptr        <= START_PTR;
      r_byte_idx   <= '0;
      r_word_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (bus.start) begin
            r_state      <= ST_ACCEPT;
            r_ptr        <= START_PTR;
            r_word_count <= '0;
          end
        end
        ST_ACCEPT: begin
          if (bus.in_valid) begin
            r_word     <= bus.in_data;
            r_last     <= bus.in_last;
            r_byte_idx <= '0;
            r_state    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_word     <= w_word_next;
          r_byte_idx <= w_last_byte ? '0 : r_byte_idx + 1'b1;
          if (w_last_byte) begin
            r_word_count <= r_word_count + 1'b1;
          end
          // The pointer never wraps; reaching the top with anything still to write is an overflow.
          if (!w_at_top) begin
            r_ptr <= r_ptr + 1'b1;
          end
          if (w_last_byte && r_last) begin
            r_state <= ST_DONE;
          end else if (w_at_top) begin
            r_state <= ST_ERR;
          end else if (w_last_byte) begin
            r_state <= ST_ACCEPT;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
